// File: rtl/axi4_b_resp_merger.sv
// Write-response merger: forwards master B responses and injects local
// SLVERR responses for dropped write bursts once their WLAST has gone by.
module axi4_b_resp_merger #(
    parameter int AXI_ID_WIDTH   = 10,
    parameter int AXI_USER_WIDTH = 2,
    parameter int DROP_DEPTH     = 4
) (
    input  logic                      axi4_aclk,
    input  logic                      axi4_arstn,
    input  logic                      drop_valid,
    input  logic [AXI_ID_WIDTH-1:0]   drop_id,
    input  logic [AXI_USER_WIDTH-1:0] drop_user,
    input  logic                      drop_l2,
    output logic                      drop_full,
    input  logic                      w_drop_last,
    input  logic                      wlast_received,
    output logic                      response_sent,
    output logic                      overflow,
    input  logic [AXI_ID_WIDTH-1:0]   m_axi4_bid,
    input  logic [1:0]                m_axi4_bresp,
    input  logic [AXI_USER_WIDTH-1:0] m_axi4_buser,
    input  logic                      m_axi4_bvalid,
    output logic                      m_axi4_bready,
    output logic [AXI_ID_WIDTH-1:0]   s_axi4_bid,
    output logic [1:0]                s_axi4_bresp,
    output logic [AXI_USER_WIDTH-1:0] s_axi4_buser,
    output logic                      s_axi4_bvalid,
    input  logic                      s_axi4_bready
);
    localparam int PW = $clog2(DROP_DEPTH);
    localparam int EW = AXI_ID_WIDTH + AXI_USER_WIDTH + 1;
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DROP_DEPTH);

    typedef enum logic [1:0] {IDLE, FWD, LOCAL} state_t;

    state_t state, state_nxt;

    logic [EW-1:0] mem [DROP_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count, wl_cnt;
    logic          prio;

    logic [EW-1:0]             head;
    logic [AXI_ID_WIDTH-1:0]   head_id;
    logic [AXI_USER_WIDTH-1:0] head_user;
    logic                      head_l2;
    logic                      empty, push, pop, local_rdy;
    logic                      load_local, load_fwd, both_pending;

    assign head      = mem[rd_ptr];
    assign head_id   = head[EW-1 -: AXI_ID_WIDTH];
    assign head_user = head[AXI_USER_WIDTH:1];
    assign head_l2   = head[0];

    assign empty     = (count == '0);
    assign drop_full = (count == FULL_CNT);
    assign push      = drop_valid & ~drop_full;
    assign local_rdy = ~empty & (head_l2 ? wlast_received : (wl_cnt != '0));
    assign both_pending = local_rdy & m_axi4_bvalid;

    always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
        if (!axi4_arstn) state <= IDLE;
        else             state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        m_axi4_bready = 1'b0;
        response_sent = 1'b0;
        pop           = 1'b0;
        load_local    = 1'b0;
        load_fwd      = 1'b0;
        unique case (state)
            IDLE: begin
                if (local_rdy && (prio || !m_axi4_bvalid)) begin
                    load_local = 1'b1;
                    state_nxt  = LOCAL;
                end else if (m_axi4_bvalid) begin
                    m_axi4_bready = 1'b1;
                    load_fwd      = 1'b1;
                    state_nxt     = FWD;
                end
            end
            FWD: begin
                if (s_axi4_bready) state_nxt = IDLE;
            end
            LOCAL: begin
                if (s_axi4_bready) begin
                    pop           = 1'b1;
                    response_sent = head_l2;
                    state_nxt     = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge axi4_aclk) begin
        if (push) mem[wr_ptr] <= {drop_id, drop_user, drop_l2};
    end

    always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
        if (!axi4_arstn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            if (drop_valid && drop_full) overflow <= 1'b1;
        end
    end

    // wl_cnt tracks L1 bursts whose WLAST is already consumed
    always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
        if (!axi4_arstn) begin
            wl_cnt <= '0;
        end else if (w_drop_last && !(pop && !head_l2)) begin
            if (wl_cnt != FULL_CNT) wl_cnt <= wl_cnt + 1'b1;
        end else if (!w_drop_last && pop && !head_l2) begin
            wl_cnt <= wl_cnt - 1'b1;
        end
    end

    always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
        if (!axi4_arstn) begin
            prio          <= 1'b0;
            s_axi4_bvalid <= 1'b0;
            s_axi4_bid    <= '0;
            s_axi4_bresp  <= 2'b00;
            s_axi4_buser  <= '0;
        end else begin
            if ((load_local || load_fwd) && both_pending) prio <= ~prio;
            if (load_local) begin
                s_axi4_bvalid <= 1'b1;
                s_axi4_bid    <= head_id;
                s_axi4_bresp  <= 2'b10;
                s_axi4_buser  <= head_user;
            end else if (load_fwd) begin
                s_axi4_bvalid <= 1'b1;
                s_axi4_bid    <= m_axi4_bid;
                s_axi4_bresp  <= m_axi4_bresp;
                s_axi4_buser  <= m_axi4_buser;
            end else if (s_axi4_bready) begin
                s_axi4_bvalid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_axi4_b_resp_merger.sv
// Scoreboard bench for axi4_b_resp_merger: directed corner cases followed
// by randomized master/drop traffic checked against in-order source queues.
module tb_axi4_b_resp_merger;
    localparam int DEPTH = 4;

    typedef struct {
        logic [9:0] id;
        logic [1:0] user;
        logic       l2;
    } lexp_t;

    typedef struct {
        logic [9:0] id;
        logic [1:0] resp;
        logic [1:0] user;
    } mexp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       drop_valid, drop_l2, drop_full;
    logic [9:0] drop_id;
    logic [1:0] drop_user;
    logic       w_drop_last, wlast_received, response_sent, overflow;
    logic [9:0] m_bid, s_bid;
    logic [1:0] m_bresp, m_buser, s_bresp, s_buser;
    logic       m_bvalid, m_bready, s_bvalid, s_bready;

    axi4_b_resp_merger #(
        .AXI_ID_WIDTH(10), .AXI_USER_WIDTH(2), .DROP_DEPTH(DEPTH)
    ) dut (
        .axi4_aclk(clk), .axi4_arstn(rst_n),
        .drop_valid(drop_valid), .drop_id(drop_id),
        .drop_user(drop_user), .drop_l2(drop_l2), .drop_full(drop_full),
        .w_drop_last(w_drop_last), .wlast_received(wlast_received),
        .response_sent(response_sent), .overflow(overflow),
        .m_axi4_bid(m_bid), .m_axi4_bresp(m_bresp),
        .m_axi4_buser(m_buser), .m_axi4_bvalid(m_bvalid),
        .m_axi4_bready(m_bready),
        .s_axi4_bid(s_bid), .s_axi4_bresp(s_bresp),
        .s_axi4_buser(s_buser), .s_axi4_bvalid(s_bvalid),
        .s_axi4_bready(s_bready)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;
    lexp_t lq[$];
    mexp_t mq[$];
    int lrd = 0, mrd = 0, nout = 0, rs_cnt = 0;
    int l1_served = 0, wdl_pulses = 0;
    int l1_wpend = 0, l2_wpend = 0;
    int src_log[$];
    bit stop = 0, m_done = 0, d_done = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drop(input logic [9:0] id, input logic [1:0] user,
                        input logic l2);
        bit full_exp;
        full_exp = ((lq.size() - lrd) == DEPTH);
        chk("drop_full", drop_full, full_exp);
        drop_valid = 1'b1;
        drop_id    = id;
        drop_user  = user;
        drop_l2    = l2;
        if (!full_exp) begin
            lq.push_back('{id, user, l2});
            if (l2) l2_wpend++;
            else    l1_wpend++;
        end
        step();
        drop_valid = 1'b0;
    endtask

    task automatic pulse_wdl();
        w_drop_last = 1'b1;
        wdl_pulses++;
        step();
        w_drop_last = 1'b0;
    endtask

    task automatic master_send(input logic [9:0] id, input logic [1:0] resp,
                               input logic [1:0] user);
        bit hs;
        bit done;
        done = 0;
        m_bid = id; m_bresp = resp; m_buser = user; m_bvalid = 1'b1;
        mq.push_back('{id, resp, user});
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            hs = m_bready;
            step();
            if (hs) done = 1;
        end
        chk("master_hs_timeout", done, 1);
        m_bvalid = 1'b0;
    endtask

    task automatic wait_out(input string nm, input int target, input int lim);
        for (int i = 0; i < lim && nout < target; i++) step();
        chk(nm, nout >= target, 1);
    endtask

    task automatic l2_clear_on_sent(input int lim);
        bit rs;
        bit done;
        done = 0;
        for (int i = 0; i < lim && !done; i++) begin
            @(negedge clk);
            rs = response_sent;
            step();
            if (rs) begin
                wlast_received = 1'b0;
                done = 1;
            end
        end
        chk("l2_sent_timeout", done, 1);
    endtask

    task automatic monitor();
        bit have_prev = 0, prev_v = 0, prev_r = 0;
        logic [13:0] prev_f = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                lrd = lq.size();
                mrd = mq.size();
                l1_served = 0;
                have_prev = 0;
                continue;
            end
            if (response_sent) rs_cnt++;
            if (have_prev && prev_v && !prev_r) begin
                chk("hold_valid", s_bvalid, 1);
                chk("hold_fields", {s_bid, s_bresp, s_buser}, prev_f);
            end
            have_prev = 1;
            prev_v = s_bvalid;
            prev_r = s_bready;
            prev_f = {s_bid, s_bresp, s_buser};
            if (s_bvalid && s_bready) begin
                nout++;
                if (s_bresp == 2'b10) begin
                    chk("local_avail", lrd < lq.size(), 1);
                    if (lrd < lq.size()) begin
                        chk("local_id", s_bid, lq[lrd].id);
                        chk("local_user", s_buser, lq[lrd].user);
                        chk("resp_sent_local", response_sent, lq[lrd].l2);
                        if (lq[lrd].l2) begin
                            chk("l2_after_wlast", wlast_received, 1);
                        end else begin
                            l1_served++;
                            chk("l1_after_wlast", l1_served <= wdl_pulses, 1);
                        end
                        lrd++;
                    end
                    src_log.push_back(1);
                end else begin
                    chk("master_avail", mrd < mq.size(), 1);
                    if (mrd < mq.size()) begin
                        chk("fwd_id", s_bid, mq[mrd].id);
                        chk("fwd_resp", s_bresp, mq[mrd].resp);
                        chk("fwd_user", s_buser, mq[mrd].user);
                        mrd++;
                    end
                    chk("resp_sent_fwd", response_sent, 0);
                    src_log.push_back(0);
                end
            end
        end
    endtask

    function automatic logic [1:0] rnd_resp();
        case ($urandom_range(0, 2))
            0:       return 2'b00;
            1:       return 2'b01;
            default: return 2'b11;
        endcase
    endfunction

    initial begin
        int n0, r0, base;
        rst_n = 1'b0;
        drop_valid = 0; drop_id = '0; drop_user = '0; drop_l2 = 0;
        w_drop_last = 0; wlast_received = 0;
        m_bid = '0; m_bresp = '0; m_buser = '0; m_bvalid = 0;
        s_bready = 0;
        fork
            monitor();
        join_none
        repeat (3) step();
        chk("rst_bvalid", s_bvalid, 0);
        chk("rst_bid", s_bid, 0);
        chk("rst_bresp", s_bresp, 0);
        chk("rst_buser", s_buser, 0);
        chk("rst_mready", m_bready, 0);
        chk("rst_rsent", response_sent, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_full", drop_full, 0);
        rst_n = 1'b1;
        s_bready = 1'b1;
        step();

        // contention right after reset: master wins first, then alternate
        drop(11, 1, 1);
        drop(12, 2, 0);
        drop(13, 3, 0);
        drop(14, 0, 0);
        chk("full_after4", drop_full, 1);
        repeat (3) pulse_wdl();
        chk("l2_head_blocks", nout, 0);
        base = src_log.size();
        r0 = rs_cnt;
        wlast_received = 1'b1;
        fork
            for (int i = 0; i < 4; i++)
                master_send(10'(20 + i), rnd_resp(), 2'(i));
            l2_clear_on_sent(100);
        join
        wait_out("rr_drain", 8, 100);
        for (int k = 0; k < 8; k++)
            if (base + k < src_log.size())
                chk("rr_order", src_log[base + k], k % 2);
        chk("rr_rsent_once", rs_cnt - r0, 1);

        // single master response latency
        n0 = nout;
        m_bid = 10'd5; m_bresp = 2'b00; m_buser = 2'd0; m_bvalid = 1'b1;
        mq.push_back('{10'd5, 2'b00, 2'd0});
        @(negedge clk);
        chk("m_bready_idle", m_bready, 1);
        chk("no_early_bvalid", s_bvalid, 0);
        step();
        m_bvalid = 1'b0;
        @(negedge clk);
        chk("fwd_latency", s_bvalid, 1);
        chk("m_bready_fwd", m_bready, 0);
        @(negedge clk);
        chk("idle_bubble", s_bvalid, 0);
        chk("master_count", nout - n0, 1);
        step();

        // L1 drop waits for its WLAST
        n0 = nout;
        drop(3, 1, 0);
        repeat (10) step();
        chk("l1_blocked", nout, n0);
        pulse_wdl();
        wait_out("l1_release", n0 + 1, 20);

        // L2 drop waits for wlast_received
        n0 = nout;
        r0 = rs_cnt;
        drop(7, 2, 1);
        repeat (5) step();
        chk("l2_blocked", nout, n0);
        wlast_received = 1'b1;
        l2_clear_on_sent(20);
        wait_out("l2_release", n0 + 1, 20);
        repeat (3) step();
        chk("l2_rsent_once", rs_cnt - r0, 1);

        // full FIFO and overflow
        n0 = nout;
        for (int i = 0; i < 4; i++) drop(10'(40 + i), 2'(i), 0);
        chk("full4", drop_full, 1);
        chk("ovf_before", overflow, 0);
        drop(10'd44, 2'd0, 0);
        chk("ovf_after", overflow, 1);
        repeat (4) pulse_wdl();
        wait_out("full_drain", n0 + 4, 40);
        repeat (5) step();
        chk("full_no_extra", nout - n0, 4);

        // backpressure then reset mid-LOCAL
        s_bready = 1'b0;
        drop(50, 3, 0);
        pulse_wdl();
        for (int i = 0; i < 20 && !s_bvalid; i++) step();
        chk("bp_valid", s_bvalid, 1);
        repeat (20) step();
        chk("bp_still_valid", s_bvalid, 1);
        chk("bp_id", s_bid, 50);
        rst_n = 1'b0;
        #1;
        chk("async_rst_bvalid", s_bvalid, 0);
        chk("async_rst_ovf", overflow, 0);
        wdl_pulses = 0;
        l1_wpend = 0;
        l2_wpend = 0;
        repeat (2) step();
        rst_n = 1'b1;
        s_bready = 1'b1;
        step();
        chk("post_rst_full", drop_full, 0);
        n0 = nout;
        drop(51, 1, 0);
        repeat (8) step();
        chk("post_rst_wlcnt0", nout, n0);
        pulse_wdl();
        wait_out("post_rst_l1", n0 + 1, 20);
        n0 = nout;
        wlast_received = 1'b1;
        repeat (5) step();
        wlast_received = 1'b0;
        chk("post_rst_empty", nout, n0);

        // randomized traffic
        l1_wpend = 0;
        l2_wpend = 0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 3)) step();
                    master_send(10'($urandom), rnd_resp(), 2'($urandom));
                end
                m_done = 1;
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 4)) step();
                    for (int j = 0; j < 500 && (lq.size() - lrd) >= DEPTH; j++)
                        step();
                    drop(10'($urandom), 2'($urandom), 1'($urandom));
                end
                d_done = 1;
            end
            begin
                while (!stop) begin
                    if (l1_wpend > 0 && $urandom_range(0, 2) == 0) begin
                        w_drop_last = 1'b1;
                        l1_wpend--;
                        wdl_pulses++;
                    end else begin
                        w_drop_last = 1'b0;
                    end
                    step();
                end
                w_drop_last = 1'b0;
            end
            begin
                bit rs;
                while (!stop) begin
                    @(negedge clk);
                    rs = response_sent;
                    step();
                    if (rs) begin
                        wlast_received = 1'b0;
                        l2_wpend--;
                    end else if (!wlast_received && l2_wpend > 0 &&
                                 $urandom_range(0, 2) == 0) begin
                        wlast_received = 1'b1;
                    end
                end
                wlast_received = 1'b0;
            end
            begin
                while (!stop) begin
                    s_bready = ($urandom_range(0, 3) != 0);
                    step();
                end
                s_bready = 1'b1;
            end
            begin
                for (int i = 0; i < 20000 && !(m_done && d_done); i++) step();
                for (int i = 0; i < 3000 &&
                     !(mrd == mq.size() && lrd == lq.size()); i++) step();
                chk("rand_drain", (mrd == mq.size()) && (lrd == lq.size()), 1);
                stop = 1;
            end
        join
        repeat (5) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
